// File: rtl/adsr_pkg.sv
// Shared definitions for the ADSR envelope path: level width, attack peak
// and the phase codes reported on the sequencer's phase output.
package adsr_pkg;

    localparam int ENV_W = 20;
    localparam logic [ENV_W-1:0] ENV_MAX = 20'hFFFFF;

    // Codes 5..7 are never entered; the sequencer recovers to PH_IDLE if seen.
    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_ATTACK  = 3'd1,
        PH_DECAY   = 3'd2,
        PH_SUSTAIN = 3'd3,
        PH_RELEASE = 3'd4
    } phase_t;

endpackage

// File: rtl/adsr_step_unit.sv
// Combinational step arithmetic for the envelope. Produces the rising
// candidate (attack, saturating at MAX_LEVEL) and the falling candidate
// (decay toward sustain, sustain clamp, release toward 0, or 0 when idle).
module adsr_step_unit
    import adsr_pkg::*;
#(
    parameter int               WIDTH     = ENV_W,
    parameter logic [WIDTH-1:0] MAX_LEVEL = ENV_MAX
) (
    input  phase_t           phase,
    input  logic [WIDTH-1:0] level,
    input  logic [WIDTH-1:0] attack_step,
    input  logic [WIDTH-1:0] decay_step,
    input  logic [WIDTH-1:0] sustain_level,
    input  logic [WIDTH-1:0] release_step,
    output logic [WIDTH-1:0] rising,
    output logic [WIDTH-1:0] falling,
    output logic [WIDTH-1:0] sustain_clamped
);

    logic [WIDTH:0]   att_sum;
    logic [WIDTH:0]   dec_diff;
    logic [WIDTH:0]   rel_diff;
    logic [WIDTH-1:0] dec_cand;
    logic [WIDTH-1:0] rel_cand;

    // One extra bit on every add/sub so overflow and borrow are visible.
    always_comb begin
        att_sum  = {1'b0, level} + {1'b0, attack_step};
        dec_diff = {1'b0, level} - {1'b0, decay_step};
        rel_diff = {1'b0, level} - {1'b0, release_step};

        sustain_clamped = (sustain_level > MAX_LEVEL) ? MAX_LEVEL : sustain_level;

        // A zero step means "jump straight to the target".
        if ((attack_step == '0) || (att_sum > {1'b0, MAX_LEVEL}))
            rising = MAX_LEVEL;
        else
            rising = att_sum[WIDTH-1:0];

        if ((decay_step == '0) || dec_diff[WIDTH] || (dec_diff[WIDTH-1:0] < sustain_clamped))
            dec_cand = sustain_clamped;
        else
            dec_cand = dec_diff[WIDTH-1:0];

        if ((release_step == '0) || rel_diff[WIDTH])
            rel_cand = '0;
        else
            rel_cand = rel_diff[WIDTH-1:0];

        case (phase)
            PH_DECAY:   falling = dec_cand;
            PH_SUSTAIN: falling = sustain_clamped;
            PH_RELEASE: falling = rel_cand;
            default:    falling = '0;
        endcase
    end

endmodule

// File: rtl/adsr_env_sequencer.sv
// ADSR envelope phase sequencer. Owns the envelope level register and the
// phase FSM, and selects between the rising and falling step candidates.
// gate is a level; tick is a one-cycle strobe with no back-pressure: a tick
// is consumed in the cycle it is high, unless a gate edge takes that cycle,
// in which case the tick is dropped and only the phase changes.
module adsr_env_sequencer
    import adsr_pkg::*;
#(
    parameter int               WIDTH     = ENV_W,
    parameter logic [WIDTH-1:0] MAX_LEVEL = ENV_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gate,
    input  logic             tick,
    input  logic [WIDTH-1:0] attack_step,
    input  logic [WIDTH-1:0] decay_step,
    input  logic [WIDTH-1:0] sustain_level,
    input  logic [WIDTH-1:0] release_step,
    output logic [WIDTH-1:0] level,
    output logic [2:0]       phase,
    output logic             mux_sel,
    output logic             busy,
    output logic             done
);

    phase_t           phase_q;
    logic             gate_q;
    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] rising;
    logic [WIDTH-1:0] falling;
    logic [WIDTH-1:0] sustain_clamped;
    logic [WIDTH-1:0] level_next;

    adsr_step_unit #(
        .WIDTH     (WIDTH),
        .MAX_LEVEL (MAX_LEVEL)
    ) u_step (
        .phase           (phase_q),
        .level           (level),
        .attack_step     (attack_step),
        .decay_step      (decay_step),
        .sustain_level   (sustain_level),
        .release_step    (release_step),
        .rising          (rising),
        .falling         (falling),
        .sustain_clamped (sustain_clamped)
    );

    assign rise       = gate & ~gate_q;
    assign fall       = ~gate & gate_q;
    assign phase      = phase_q;
    assign busy       = (phase_q != PH_IDLE);
    assign mux_sel    = (phase_q != PH_ATTACK);
    assign level_next = mux_sel ? falling : rising;

    // Phase FSM, gate edge register and level register; edges beat ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            level   <= '0;
            done    <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            gate_q <= gate;
            done   <= 1'b0;
            case (phase_q)
                PH_IDLE, PH_ATTACK, PH_DECAY, PH_SUSTAIN, PH_RELEASE: begin
                    if (rise) begin
                        // Retrigger keeps the current level.
                        phase_q <= PH_ATTACK;
                    end else if (fall) begin
                        if ((phase_q == PH_ATTACK) || (phase_q == PH_DECAY) ||
                            (phase_q == PH_SUSTAIN))
                            phase_q <= PH_RELEASE;
                    end else if (tick && (phase_q != PH_IDLE)) begin
                        level <= level_next;
                        case (phase_q)
                            PH_ATTACK:  if (level_next == MAX_LEVEL) phase_q <= PH_DECAY;
                            PH_DECAY:   if (level_next == sustain_clamped) phase_q <= PH_SUSTAIN;
                            PH_RELEASE: begin
                                if (level_next == '0) begin
                                    phase_q <= PH_IDLE;
                                    done    <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    phase_q <= PH_IDLE;
                    level   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adsr_env_sequencer.sv
// Self-checking bench for adsr_env_sequencer: table of single-cycle vectors,
// hand-written multi-cycle sequences, and random stimulus against an
// arithmetic reference model feeding an expected-value queue.
module tb_adsr_env_sequencer;
    import adsr_pkg::*;

    localparam int W    = 20;
    localparam int MAXV = 'hFFFFF;
    localparam int SBW  = 26;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         gate = 1'b0;
    logic         tick = 1'b0;
    logic [W-1:0] attack_step = '0;
    logic [W-1:0] decay_step = '0;
    logic [W-1:0] sustain_level = '0;
    logic [W-1:0] release_step = '0;
    logic [W-1:0] level;
    logic [2:0]   phase;
    logic         mux_sel;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    adsr_env_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gate          (gate),
        .tick          (tick),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .level         (level),
        .phase         (phase),
        .mux_sel       (mux_sel),
        .busy          (busy),
        .done          (done)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [SBW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic chk_out(input string nm, input int ph, input int lv, input bit d);
        chk({nm, ".phase"},   {29'd0, phase}, ph);
        chk({nm, ".level"},   {12'd0, level}, lv);
        chk({nm, ".done"},    {31'd0, done}, {31'd0, d});
        chk({nm, ".busy"},    {31'd0, busy}, {31'd0, (ph != 0)});
        chk({nm, ".mux_sel"}, {31'd0, mux_sel}, {31'd0, (ph != 1)});
    endtask

    // ---------------- reference model ----------------
    int m_ph, m_lv;
    bit m_gq, m_done;

    function automatic logic [SBW-1:0] pack_exp(input int ph, input int lv, input bit d);
        logic [2:0]   p3;
        logic [W-1:0] l20;
        p3  = ph[2:0];
        l20 = lv[W-1:0];
        return {p3, l20, d, (ph != 0), (ph != 1)};
    endfunction

    task automatic model_reset();
        m_ph = 0; m_lv = 0; m_gq = 0; m_done = 0;
    endtask

    // One clock of the envelope rules, on plain integers.
    task automatic model_step();
        int as, ds, sus, rs;
        bit rise, fall;
        as   = int'(attack_step);
        ds   = int'(decay_step);
        rs   = int'(release_step);
        sus  = (int'(sustain_level) > MAXV) ? MAXV : int'(sustain_level);
        rise = gate && !m_gq;
        fall = !gate && m_gq;
        m_done = 0;
        if (rise) begin
            m_ph = 1;
        end else if (fall) begin
            if (m_ph >= 1 && m_ph <= 3) m_ph = 4;
        end else if (tick) begin
            case (m_ph)
                1: begin
                    m_lv = (as == 0 || m_lv + as > MAXV) ? MAXV : m_lv + as;
                    if (m_lv == MAXV) m_ph = 2;
                end
                2: begin
                    m_lv = (ds == 0 || m_lv - ds < sus) ? sus : m_lv - ds;
                    if (m_lv == sus) m_ph = 3;
                end
                3: m_lv = sus;
                4: begin
                    m_lv = (rs == 0 || rs >= m_lv) ? 0 : m_lv - rs;
                    if (m_lv == 0) begin m_ph = 0; m_done = 1; end
                end
                default: ;
            endcase
        end
        m_gq = gate;
        exp_q.push_back(pack_exp(m_ph, m_lv, m_done));
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic g, input logic t);
        logic [SBW-1:0] e;
        gate = g;
        tick = t;
        @(posedge clk);
        model_step();
        #1;
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard: expected queue empty");
        end else begin
            e = exp_q.pop_front();
            chk("scoreboard", {6'd0, phase, level, done, busy, mux_sel}, {6'd0, e});
        end
        tick = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_step();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return W'($urandom_range(1, 'hFF));
            2:       return W'($urandom_range(1, 'hFFFF));
            default: return W'($urandom_range(1, 'hFFFFF));
        endcase
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic         g;
        logic         t;
        logic [W-1:0] sus;
        logic [W-1:0] rel;
        logic [2:0]   ph;
        logic [W-1:0] lv;
        logic         d;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int dn;
        int expv;

        // Zero attack/decay steps; sustain and release change per row.
        tbl[0]  = '{1'b1, 1'b1, 20'h12345, 20'h00000, 3'd1, 20'h00000, 1'b0}; // rise beats tick
        tbl[1]  = '{1'b1, 1'b1, 20'h12345, 20'h00000, 3'd2, 20'hFFFFF, 1'b0}; // instant attack
        tbl[2]  = '{1'b1, 1'b1, 20'h12345, 20'h00000, 3'd3, 20'h12345, 1'b0}; // instant decay
        tbl[3]  = '{1'b1, 1'b1, 20'h80000, 20'h00000, 3'd3, 20'h80000, 1'b0}; // sustain rises
        tbl[4]  = '{1'b1, 1'b0, 20'h20000, 20'h00000, 3'd3, 20'h80000, 1'b0}; // no tick, hold
        tbl[5]  = '{1'b1, 1'b1, 20'h20000, 20'h00000, 3'd3, 20'h20000, 1'b0}; // sustain tracks
        tbl[6]  = '{1'b0, 1'b1, 20'h20000, 20'h00000, 3'd4, 20'h20000, 1'b0}; // fall beats tick
        tbl[7]  = '{1'b0, 1'b0, 20'h20000, 20'h00000, 3'd4, 20'h20000, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 20'h20000, 20'h08000, 3'd4, 20'h18000, 1'b0}; // release step
        tbl[9]  = '{1'b0, 1'b1, 20'h20000, 20'h20000, 3'd0, 20'h00000, 1'b1}; // floored at 0
        tbl[10] = '{1'b0, 1'b0, 20'h20000, 20'h20000, 3'd0, 20'h00000, 1'b0}; // single pulse
        tbl[11] = '{1'b0, 1'b1, 20'h20000, 20'h20000, 3'd0, 20'h00000, 1'b0}; // idle ignores tick

        // Power-on reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1 chk_out("reset.init", 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // Table-driven vectors.
        attack_step = '0;
        decay_step  = '0;
        for (int i = 0; i < 12; i++) begin
            sustain_level = tbl[i].sus;
            release_step  = tbl[i].rel;
            cyc(tbl[i].g, tbl[i].t);
            chk_out($sformatf("table[%0d]", i), int'(tbl[i].ph), int'(tbl[i].lv), tbl[i].d);
        end

        // Retrigger from RELEASE keeps the level.
        attack_step = '0; decay_step = '0;
        sustain_level = 20'h50000; release_step = 20'h20000;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk_out("retrig.sustain", 3, 'h50000, 0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk_out("retrig.release", 4, 'h30000, 0);
        cyc(1'b1, 1'b0);
        chk_out("retrig.rise", 1, 'h30000, 0);
        attack_step = 20'h01000;
        cyc(1'b1, 1'b1);
        chk_out("retrig.step", 1, 'h31000, 0);
        release_step = '0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk_out("retrig.to_idle", 0, 0, 1);

        // Full envelope, tick every 4 clocks.
        attack_step = 20'h40000; decay_step = 20'h10000;
        sustain_level = 20'h80000; release_step = 20'h20000;
        cyc(1'b1, 1'b0);
        chk_out("full.rise", 1, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            repeat (3) cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b1);
            expv = (k * 'h40000 > MAXV) ? MAXV : k * 'h40000;
            chk_out($sformatf("full.attack%0d", k), (k < 4) ? 1 : 2, expv, 0);
        end
        for (int k = 1; k <= 8; k++) begin
            repeat (3) cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b1);
            expv = (k < 8) ? MAXV - k * 'h10000 : 'h80000;
            chk_out($sformatf("full.decay%0d", k), (k < 8) ? 2 : 3, expv, 0);
        end
        cyc(1'b0, 1'b0);
        chk_out("full.fall", 4, 'h80000, 0);
        dn = 0;
        for (int k = 1; k <= 4; k++) begin
            repeat (3) begin cyc(1'b0, 1'b0); dn += int'(done); end
            cyc(1'b0, 1'b1);
            dn += int'(done);
            chk_out($sformatf("full.release%0d", k), (k < 4) ? 4 : 0, 'h80000 - k * 'h20000, (k == 4));
        end
        repeat (4) begin cyc(1'b0, 1'b0); dn += int'(done); end
        chk("full.done_count", dn, 1);

        // Asynchronous reset in the middle of ATTACK.
        attack_step = 20'h40000;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk_out("areset.before", 1, 'h40000, 0);
        #3 rst_n = 1'b0;
        #1 chk_out("areset.during", 0, 0, 0);
        gate = 1'b0;
        model_reset();
        @(posedge clk);
        #1 chk_out("areset.held", 0, 0, 0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1);
        chk_out("areset.after", 0, 0, 0);

        // Random stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            if (n % 40 == 0) begin
                attack_step   = rand_step();
                decay_step    = rand_step();
                release_step  = rand_step();
                sustain_level = W'($urandom_range(0, MAXV));
            end
            if ($urandom_range(0, 39) == 0) gate = ~gate;
            cyc(gate, ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
